// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter for AXI-Stream: one grant per packet, held until the
// tlast beat is accepted, with a single registered output stage running at full rate.
module stream_rr_arbiter #(
    parameter int n_in = 4,
    parameter int nb   = 40,
    parameter int iw   = (n_in > 1) ? $clog2(n_in) : 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [n_in*nb-1:0]   in_tdata,
    input  logic [n_in-1:0]      in_tvalid,
    input  logic [n_in-1:0]      in_tlast,
    output logic [n_in-1:0]      in_tready,
    output logic [nb-1:0]        out_tdata,
    output logic                 out_tlast,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic [iw-1:0]        grant_id,
    output logic                 busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [iw-1:0] last_idx_c = iw'(n_in - 1);

    state_t            state_r;
    logic [iw-1:0]     last_grant_r;
    logic [iw-1:0]     grant_id_r;
    logic [nb-1:0]     out_tdata_r;
    logic              out_tlast_r;
    logic              out_tvalid_r;

    logic [iw-1:0]     winner_hi_s;
    logic [iw-1:0]     winner_lo_s;
    logic [iw-1:0]     winner_s;
    logic              found_hi_s;
    logic              found_lo_s;
    logic              any_valid_s;
    logic [nb-1:0]     sel_tdata_s;
    logic              sel_tvalid_s;
    logic              sel_tlast_s;
    logic              can_load_s;
    logic              beat_acc_s;
    logic [n_in-1:0]   in_tready_s;

    // Rotating priority: first valid index above last_grant, otherwise lowest valid index.
    always_comb begin
        winner_hi_s = '0;
        winner_lo_s = '0;
        found_hi_s  = 1'b0;
        found_lo_s  = 1'b0;
        for (int i = 0; i < n_in; i++) begin
            winner_hi_s = (!found_hi_s && in_tvalid[i] && (i[iw-1:0] > last_grant_r))
                          ? i[iw-1:0] : winner_hi_s;
            found_hi_s  = found_hi_s | (in_tvalid[i] & (i[iw-1:0] > last_grant_r));
            winner_lo_s = (!found_lo_s && in_tvalid[i]) ? i[iw-1:0] : winner_lo_s;
            found_lo_s  = found_lo_s | in_tvalid[i];
        end
        winner_s    = found_hi_s ? winner_hi_s : winner_lo_s;
        any_valid_s = found_lo_s;
    end

    // Route the granted requester's beat and build the one-hot ready.
    always_comb begin
        sel_tdata_s  = '0;
        sel_tvalid_s = 1'b0;
        sel_tlast_s  = 1'b0;
        in_tready_s  = '0;
        can_load_s   = ~out_tvalid_r | out_tready;
        for (int i = 0; i < n_in; i++) begin
            sel_tdata_s    = (grant_id_r == i[iw-1:0]) ? in_tdata[i*nb +: nb] : sel_tdata_s;
            sel_tvalid_s   = (grant_id_r == i[iw-1:0]) ? in_tvalid[i] : sel_tvalid_s;
            sel_tlast_s    = (grant_id_r == i[iw-1:0]) ? in_tlast[i] : sel_tlast_s;
            in_tready_s[i] = (state_r == LOCK) && (grant_id_r == i[iw-1:0]) && can_load_s;
        end
        beat_acc_s = (state_r == LOCK) & sel_tvalid_s & can_load_s;
    end

    // Arbitration FSM: grant on any request in IDLE, release after the tlast beat is taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r      <= IDLE;
            last_grant_r <= last_idx_c;
            grant_id_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        grant_id_r <= winner_s;
                        state_r    <= LOCK;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                LOCK: begin
                    if (beat_acc_s && sel_tlast_s) begin
                        state_r      <= IDLE;
                        last_grant_r <= grant_id_r;
                    end else begin
                        state_r      <= LOCK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output register: load on accept, drain on downstream ready, otherwise hold.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_tdata_r  <= '0;
            out_tlast_r  <= 1'b0;
            out_tvalid_r <= 1'b0;
        end else if (beat_acc_s) begin
            out_tdata_r  <= sel_tdata_s;
            out_tlast_r  <= sel_tlast_s;
            out_tvalid_r <= 1'b1;
        end else if (out_tready) begin
            out_tvalid_r <= 1'b0;
        end else begin
            out_tvalid_r <= out_tvalid_r;
        end
    end

    assign in_tready  = in_tready_s;
    assign out_tdata  = out_tdata_r;
    assign out_tlast  = out_tlast_r;
    assign out_tvalid = out_tvalid_r;
    assign grant_id   = grant_id_r;
    assign busy       = (state_r == LOCK);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: packet-level rotation model feeds an expected
// beat queue, a negedge monitor pops and compares every accepted output beat.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int NB = 40;
    localparam int IW = 2;

    logic              aclk;
    logic              aresetn;
    logic [N*NB-1:0]   in_tdata;
    logic [N-1:0]      in_tvalid;
    logic [N-1:0]      in_tlast;
    logic [N-1:0]      in_tready;
    logic [NB-1:0]     out_tdata;
    logic              out_tlast;
    logic              out_tvalid;
    logic              out_tready;
    logic [IW-1:0]     grant_id;
    logic              busy;

    stream_rr_arbiter #(.n_in(N), .nb(NB), .iw(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid),
        .out_tready(out_tready), .grant_id(grant_id), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [NB:0] src_q   [N][$];
    logic [NB:0] stage_q [N][$];
    int          plen_q  [N][$];
    logic [NB:0] exp_q   [$];
    logic        mid     [N];
    logic        hold    [N];
    bit          gaps_en;
    bit          mon_en;
    int          rdy_mode;
    int          model_last;

    logic            snap_tvalid, snap_tlast, snap_busy;
    logic [NB-1:0]   snap_tdata;
    logic [N-1:0]    snap_tready, snap_acc;
    logic [IW-1:0]   snap_grant;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit any_src();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r = r | (src_q[i].size() > 0);
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_tvalid[i] = (src_q[i].size() > 0) && !hold[i] &&
                           !(gaps_en && mid[i] && ($urandom_range(0, 3) == 0));
            if (src_q[i].size() > 0) begin
                in_tdata[i*NB +: NB] = src_q[i][0][NB-1:0];
                in_tlast[i]          = src_q[i][0][NB];
            end else begin
                in_tdata[i*NB +: NB] = '0;
                in_tlast[i]          = 1'b0;
            end
        end
        out_tready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
    endtask

    task automatic cycle();
        logic [NB:0] b;
        @(negedge aclk);
        snap_tvalid = out_tvalid;
        snap_tlast  = out_tlast;
        snap_tdata  = out_tdata;
        snap_busy   = busy;
        snap_tready = in_tready;
        snap_grant  = grant_id;
        snap_acc    = in_tvalid & in_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (snap_acc[i] && src_q[i].size() > 0) begin
                b      = src_q[i].pop_front();
                mid[i] = !b[NB];
            end
        end
        drive();
    endtask

    task automatic add_beat(input int i, input logic [NB-1:0] d, input logic l);
        src_q[i].push_back({l, d});
        stage_q[i].push_back({l, d});
    endtask

    task automatic add_pkt_rand(input int i, input int len);
        for (int j = 0; j < len; j++)
            add_beat(i, {4'(i), 4'(j), 32'($urandom())}, (j == len - 1));
        plen_q[i].push_back(len);
    endtask

    // Reference: serve pending packets in strict rotation starting after the last grant.
    task automatic schedule();
        int w, len;
        forever begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && plen_q[(model_last + k) % N].size() > 0) w = (model_last + k) % N;
            if (w < 0) break;
            len = plen_q[w].pop_front();
            for (int j = 0; j < len; j++) exp_q.push_back(stage_q[w].pop_front());
            model_last = w;
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete(); stage_q[i].delete(); plen_q[i].delete();
            mid[i] = 1'b0; hold[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        clear_all();
        drive();
        cycle();
        cycle();
        aresetn    = 1'b1;
        model_last = N - 1;
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int cyc = 0;
        while ((exp_q.size() > 0 || any_src()) && cyc < budget) begin
            cycle();
            cyc++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic count_until_empty(input string name, input int want);
        int cyc = 0;
        while (any_src() && cyc < 100) begin
            cycle();
            cyc++;
        end
        chk(name, 64'(cyc), 64'(want));
    endtask

    // Monitor: scoreboard compare, stall stability and one-hot ready on every cycle.
    initial begin
        logic        prev_stall;
        logic [NB:0] prev_beat, e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge aclk);
            if (aresetn !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                chk("ready_onehot", 64'($countones(in_tready) > 1), 64'd0);
                if (prev_stall)
                    chk("stall_stable", {23'd0, out_tvalid, out_tlast, out_tdata},
                        {23'd0, 1'b1, prev_beat});
                if (mon_en && out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {24'd0, out_tlast, out_tdata}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {24'd0, out_tlast, out_tdata}, {24'd0, e});
                    end
                end
                prev_stall = out_tvalid && !out_tready;
                prev_beat  = {out_tlast, out_tdata};
            end
        end
    end

    initial begin
        logic [NB-1:0] bp_beat;
        aresetn = 1'b0; in_tdata = '0; in_tvalid = '0; in_tlast = '0; out_tready = 1'b1;
        rdy_mode = 1; gaps_en = 1'b0; mon_en = 1'b1; model_last = N - 1;

        apply_reset();
        chk("rst_tvalid", 64'(snap_tvalid), 64'd0);
        chk("rst_tdata", 64'(snap_tdata), 64'd0);
        chk("rst_tlast", 64'(snap_tlast), 64'd0);
        chk("rst_tready", 64'(snap_tready), 64'd0);
        chk("rst_busy", 64'(snap_busy), 64'd0);
        chk("rst_grant", 64'(snap_grant), 64'd0);

        // Fairness: 0,1,3 each with two 2-beat packets, 3 cycles per packet.
        for (int r = 0; r < 2; r++) begin
            add_pkt_rand(0, 2); add_pkt_rand(1, 2); add_pkt_rand(3, 2);
        end
        schedule();
        drive();
        count_until_empty("fair_cycles", 18);
        drain("fair_drain", 50);

        // Single requester latency on input 2.
        add_beat(2, 40'h11, 1'b0); add_beat(2, 40'h22, 1'b0); add_beat(2, 40'h33, 1'b1);
        plen_q[2].push_back(3);
        schedule();
        drive();
        cycle(); chk("lat_c0_tvalid", 64'(snap_tvalid), 64'd0); chk("lat_c0_busy", 64'(snap_busy), 64'd0);
        cycle(); chk("lat_c1_busy", 64'(snap_busy), 64'd1); chk("lat_c1_grant", 64'(snap_grant), 64'd2);
                 chk("lat_c1_tready", 64'(snap_tready), 64'h4); chk("lat_c1_tvalid", 64'(snap_tvalid), 64'd0);
        cycle(); chk("lat_c2_tvalid", 64'(snap_tvalid), 64'd1); chk("lat_c2_tdata", 64'(snap_tdata), 64'h11);
        cycle(); chk("lat_c3_tdata", 64'(snap_tdata), 64'h22); chk("lat_c3_busy", 64'(snap_busy), 64'd1);
        cycle(); chk("lat_c4_busy", 64'(snap_busy), 64'd0); chk("lat_c4_tlast", 64'(snap_tlast), 64'd1);
        drain("lat_drain", 50);

        // Backpressure: stall output for 5 cycles after beat 1 is registered.
        add_pkt_rand(0, 4);
        bp_beat = src_q[0][1][NB-1:0];
        schedule();
        drive();
        cycle(); cycle(); cycle();
        rdy_mode = 0;
        drive();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_tready", 64'(snap_tready), 64'd0);
            chk("bp_tdata", 64'(snap_tdata), 64'(bp_beat));
        end
        rdy_mode = 1;
        drive();
        drain("bp_drain", 50);

        // Grant hold: input 1 stalls mid-packet while input 0 requests.
        add_pkt_rand(1, 3);
        schedule();
        drive();
        cycle(); cycle();
        hold[1] = 1'b1;
        add_pkt_rand(0, 2);
        schedule();
        drive();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("hold_tready0", 64'(snap_tready[0]), 64'd0);
            chk("hold_grant", 64'(snap_grant), 64'd1);
            chk("hold_busy", 64'(snap_busy), 64'd1);
        end
        hold[1] = 1'b0;
        drive();
        drain("hold_drain", 50);

        // Reset in the middle of a 4-beat packet.
        mon_en = 1'b0;
        add_pkt_rand(2, 4);
        drive();
        cycle(); cycle(); cycle();
        aresetn = 1'b0;
        cycle();
        aresetn = 1'b1;
        clear_all();
        model_last = N - 1;
        drive();
        cycle();
        chk("mrst_tvalid", 64'(snap_tvalid), 64'd0);
        chk("mrst_tready", 64'(snap_tready), 64'd0);
        chk("mrst_busy", 64'(snap_busy), 64'd0);
        mon_en = 1'b1;
        add_pkt_rand(3, 1); add_pkt_rand(0, 1);
        schedule();
        drive();
        cycle(); cycle();
        chk("mrst_first_grant", 64'(snap_grant), 64'd0);
        chk("mrst_first_tready", 64'(snap_tready), 64'h1);
        drain("mrst_drain", 50);

        // Single-beat packets from all inputs: one every two cycles, order 0..3.
        apply_reset();
        for (int i = 0; i < N; i++) add_pkt_rand(i, 1);
        schedule();
        drive();
        count_until_empty("single_cycles", 8);
        drain("single_drain", 50);

        // Randomized traffic with mid-packet valid gaps and random backpressure.
        gaps_en  = 1'b1;
        rdy_mode = 2;
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < N; i++) begin
                int np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_pkt_rand(i, $urandom_range(1, 4));
            end
            schedule();
            drive();
            drain("rand_drain", 600);
        end

        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
